// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Packs mnemonic-selector instruction requests into 32-bit MIPS
//                words and streams them to an instruction-memory write port at
//                consecutive word addresses, over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_sel,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_shamt,
    input  logic [15:0]   in_imm,
    input  logic [25:0]   in_target,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [31:0]   im_wdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          err_illegal
);

    // Number of words the memory holds; count saturates here.
    localparam logic [AW:0] C_CAPACITY = {1'b1, {AW{1'b0}}};

    // Instruction formats.
    localparam logic [1:0] C_FMT_R = 2'd0;
    localparam logic [1:0] C_FMT_I = 2'd1;
    localparam logic [1:0] C_FMT_J = 2'd2;

    localparam logic [5:0] C_OP_J = 6'b000010;

    // Registered state.
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [AW-1:0] ptr_q;
    logic [AW:0]   count_q;
    logic          err_q;

    // Encoder intermediates.
    logic [1:0]  w_fmt;
    logic        w_legal;
    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [31:0] w_word;
    logic        w_accept;

    assign full        = (count_q == C_CAPACITY);
    assign in_ready    = ~full & ~start;
    assign w_accept    = in_valid & in_ready;

    assign im_we       = we_q;
    assign im_addr     = addr_q;
    assign im_wdata    = wdata_q;
    assign count       = count_q;
    assign err_illegal = err_q;

    // Decode the selector into format, opcode/funct and canonical fields.
    always_comb begin
        w_fmt   = C_FMT_R;
        w_legal = 1'b1;
        w_op    = 6'b000000;
        w_funct = 6'b000000;
        w_rs    = in_rs;
        w_rt    = in_rt;
        w_rd    = in_rd;
        w_shamt = 5'd0;
        case (in_sel)
            5'd0:  w_funct = 6'b100000;             // add
            5'd1:  w_funct = 6'b100001;             // addu
            5'd2:  w_funct = 6'b100010;             // sub
            5'd3:  w_funct = 6'b100011;             // subu
            5'd4:  w_funct = 6'b100100;             // and
            5'd5:  w_funct = 6'b100101;             // or
            5'd6:  w_funct = 6'b100111;             // nor
            5'd7:  w_funct = 6'b101010;             // slt
            5'd8:  w_funct = 6'b101011;             // sltu
            5'd9: begin                             // sll: immediate shift, no rs
                w_funct = 6'b000000;
                w_rs    = 5'd0;
                w_shamt = in_shamt;
            end
            5'd10: begin                            // srl: immediate shift, no rs
                w_funct = 6'b000010;
                w_rs    = 5'd0;
                w_shamt = in_shamt;
            end
            5'd11: w_funct = 6'b000100;             // sllv
            5'd12: w_funct = 6'b000110;             // srlv
            5'd13: begin                            // jr: only rs is meaningful
                w_funct = 6'b001000;
                w_rt    = 5'd0;
                w_rd    = 5'd0;
            end
            5'd14: begin                            // jalr: rt unused
                w_funct = 6'b001001;
                w_rt    = 5'd0;
            end
            5'd16: begin w_fmt = C_FMT_I; w_op = 6'b001000; end  // addi
            5'd17: begin w_fmt = C_FMT_I; w_op = 6'b001100; end  // andi
            5'd18: begin w_fmt = C_FMT_I; w_op = 6'b001101; end  // ori
            5'd19: begin w_fmt = C_FMT_I; w_op = 6'b001010; end  // slti
            5'd20: begin                                         // lui: no rs
                w_fmt = C_FMT_I;
                w_op  = 6'b001111;
                w_rs  = 5'd0;
            end
            5'd21: begin w_fmt = C_FMT_I; w_op = 6'b100011; end  // lw
            5'd22: begin w_fmt = C_FMT_I; w_op = 6'b101011; end  // sw
            5'd23: begin w_fmt = C_FMT_I; w_op = 6'b000100; end  // beq
            5'd24: begin w_fmt = C_FMT_I; w_op = 6'b000101; end  // bne
            5'd25: begin w_fmt = C_FMT_J; w_op = C_OP_J;    end  // j
            default: w_legal = 1'b0;                // 15, 26..31
        endcase
    end

    // Assemble the 32-bit word from the decoded fields.
    always_comb begin
        w_word = {w_op, w_rs, w_rt, w_rd, w_shamt, w_funct};
        case (w_fmt)
            C_FMT_I: w_word = {w_op, w_rs, w_rt, in_imm};
            C_FMT_J: w_word = {C_OP_J, in_target};
            default: w_word = {w_op, w_rs, w_rt, w_rd, w_shamt, w_funct};
        endcase
    end

    // Accept requests, register the write, track pointer/count/error.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else if (start) begin
            // A write presented this cycle has already been seen by memory.
            we_q    <= 1'b0;
            ptr_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else if (w_accept) begin
            if (w_legal) begin
                we_q    <= 1'b1;
                addr_q  <= ptr_q;
                wdata_q <= w_word;
                // Pointer may roll to 0 on the last word; full blocks reuse.
                ptr_q   <= ptr_q + {{(AW-1){1'b0}}, 1'b1};
                count_q <= count_q + {{AW{1'b0}}, 1'b1};
            end else begin
                we_q    <= 1'b0;
                err_q   <= 1'b1;
            end
        end else begin
            we_q <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
module tb_instr_encoder;

    localparam int AW  = 2;
    localparam int CAP = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_sel, in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        im_we;
    logic [AW-1:0] im_addr;
    logic [31:0] im_wdata;
    logic [AW:0] count;
    logic        full;
    logic        err_illegal;

    int total = 0;
    int bad   = 0;

    instr_encoder #(.AW(AW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_sel(in_sel), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
        .in_target(in_target), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .count(count), .full(full),
        .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    // Reference tables in decimal, indexed by selector.
    int unsigned fn_r[15] = '{32, 33, 34, 35, 36, 37, 39, 42, 43, 0, 2, 4, 6, 8, 9};
    int unsigned op_i[9]  = '{8, 12, 13, 10, 15, 35, 43, 4, 5};

    // Reference model state.
    int unsigned m_count;
    bit          m_err;
    bit          e_we;
    int unsigned e_addr;
    int unsigned e_word;

    function automatic void ref_enc(input int unsigned sel, rs, rt, rd, sh, imm, tgt,
                                    output bit legal, output int unsigned w);
        int unsigned r_s, r_t, r_d, s_h;
        legal = 1'b1;
        w = 0;
        r_s = rs; r_t = rt; r_d = rd; s_h = sh;
        if (sel < 15) begin
            if (sel == 9 || sel == 10) r_s = 0; else s_h = 0;
            if (sel == 13) begin r_t = 0; r_d = 0; end
            if (sel == 14) r_t = 0;
            w = r_s * 2097152 + r_t * 65536 + r_d * 2048 + s_h * 64 + fn_r[sel];
        end else if (sel >= 16 && sel <= 24) begin
            if (sel == 20) r_s = 0;
            w = op_i[sel-16] * 67108864 + r_s * 2097152 + r_t * 65536 + imm;
        end else if (sel == 25) begin
            w = 2 * 67108864 + tgt;
        end else begin
            legal = 1'b0;
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        m_count = 0; m_err = 0; e_we = 0; e_addr = 0; e_word = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ":we"},    {31'd0, im_we}, {31'd0, e_we});
        chk({tag, ":addr"},  {30'd0, im_addr}, e_addr);
        chk({tag, ":wdata"}, im_wdata, e_word);
        chk({tag, ":count"}, {29'd0, count}, m_count);
        chk({tag, ":full"},  {31'd0, full}, {31'd0, m_count == CAP});
        chk({tag, ":err"},   {31'd0, err_illegal}, {31'd0, m_err});
    endtask

    // One clock: drive, check ready, clock, advance model, check outputs.
    task automatic cycle(input bit v, input bit st, input int unsigned sel, rs, rt, rd, sh,
                         input int unsigned imm, tgt, input string tag);
        bit exp_ready, legal;
        int unsigned w;
        in_valid = v; start = st;
        in_sel = sel[4:0]; in_rs = rs[4:0]; in_rt = rt[4:0]; in_rd = rd[4:0];
        in_shamt = sh[4:0]; in_imm = imm[15:0]; in_target = tgt[25:0];
        #1;
        exp_ready = (m_count != CAP) && !st;
        chk({tag, ":ready"}, {31'd0, in_ready}, {31'd0, exp_ready});
        @(posedge clk); #1;
        ref_enc(sel, rs, rt, rd, sh, imm, tgt, legal, w);
        e_we = 0;
        if (st) begin
            m_count = 0; m_err = 0;
        end else if (v && exp_ready) begin
            if (legal) begin
                e_we = 1; e_addr = m_count; e_word = w; m_count++;
            end else begin
                m_err = 1;
            end
        end
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic do_start(input string tag);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    typedef struct {
        int unsigned sel, rs, rt, rd, sh, imm, tgt;
        logic [31:0] word;
        bit          legal;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{0, 1, 2, 3, 0, 0, 0, 32'h00221820, 1};        // add
        vecs[1] = '{9, 7, 1, 2, 4, 0, 0, 32'h00011100, 1};        // sll, rs forced
        vecs[2] = '{25, 0, 0, 0, 0, 0, 32'h0100000, 32'h08100000, 1}; // j
        vecs[3] = '{13, 31, 5, 5, 5, 0, 0, 32'h03E00008, 1};      // jr
        vecs[4] = '{16, 0, 8, 0, 0, 16'h0005, 0, 32'h20080005, 1}; // addi
        vecs[5] = '{21, 29, 9, 0, 0, 16'hFFFC, 0, 32'h8FA9FFFC, 1}; // lw
        vecs[6] = '{20, 3, 4, 0, 0, 16'h1234, 0, 32'h3C041234, 1}; // lui
        vecs[7] = '{14, 4, 7, 31, 3, 0, 0, 32'h0080F809, 1};      // jalr
        vecs[8] = '{11, 1, 2, 3, 7, 0, 0, 32'h00221804, 1};       // sllv, shamt dropped
        vecs[9] = '{26, 1, 2, 3, 4, 0, 0, 32'h00000000, 0};       // illegal

        rstn = 1'b0; start = 0; in_valid = 0;
        in_sel = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_shamt = 0;
        in_imm = 0; in_target = 0;
        model_clear();
        #2;
        check_outputs("reset");
        chk("reset:ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        // Test plan: add after reset.
        cycle(1, 0, 0, 1, 2, 3, 0, 0, 0, "add");
        chk("add:word", im_wdata, 32'h00221820);
        chk("add:cnt", {29'd0, count}, 32'd1);
        idle("add_idle");

        // Table of single encodings.
        foreach (vecs[i]) begin
            do_start("tbl_start");
            cycle(1, 0, vecs[i].sel, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh,
                  vecs[i].imm, vecs[i].tgt, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d:we_const", i), {31'd0, im_we}, {31'd0, vecs[i].legal});
            if (vecs[i].legal)
                chk($sformatf("tbl%0d:word_const", i), im_wdata, vecs[i].word);
            chk($sformatf("tbl%0d:err_const", i), {31'd0, err_illegal}, {31'd0, !vecs[i].legal});
        end

        // Back-to-back addi then lw.
        do_start("b2b_start");
        cycle(1, 0, 16, 0, 8, 0, 0, 16'h0005, 0, "b2b0");
        chk("b2b0:addr", {30'd0, im_addr}, 32'd0);
        cycle(1, 0, 21, 29, 9, 0, 0, 16'hFFFC, 0, "b2b1");
        chk("b2b1:we", {31'd0, im_we}, 32'd1);
        chk("b2b1:addr", {30'd0, im_addr}, 32'd1);
        chk("b2b1:word", im_wdata, 32'h8FA9FFFC);

        // Illegal selector between two legal words.
        do_start("ill_start");
        cycle(1, 0, 0, 1, 2, 3, 0, 0, 0, "ill0");
        cycle(1, 0, 15, 1, 2, 3, 0, 0, 0, "ill1");
        chk("ill1:we", {31'd0, im_we}, 32'd0);
        chk("ill1:err", {31'd0, err_illegal}, 32'd1);
        cycle(1, 0, 1, 4, 5, 6, 0, 0, 0, "ill2");
        chk("ill2:addr", {30'd0, im_addr}, 32'd1);
        chk("ill2:err_sticky", {31'd0, err_illegal}, 32'd1);
        do_start("ill_clear");
        chk("ill_clear:err", {31'd0, err_illegal}, 32'd0);
        chk("ill_clear:cnt", {29'd0, count}, 32'd0);

        // Fill to capacity with continuous valid; 5th held until start.
        for (int k = 0; k < 4; k++)
            cycle(1, 0, 18, k, k + 1, 0, 0, 16'h0100 + k, 0, $sformatf("full%0d", k));
        chk("full:addr3", {30'd0, im_addr}, 32'd3);
        chk("full:flag", {31'd0, full}, 32'd1);
        chk("full:ready", {31'd0, in_ready}, 32'd0);
        cycle(1, 0, 18, 9, 9, 0, 0, 16'h0999, 0, "full_held");
        chk("full_held:we", {31'd0, im_we}, 32'd0);
        cycle(1, 1, 18, 9, 9, 0, 0, 16'h0999, 0, "full_start");
        cycle(1, 0, 18, 9, 9, 0, 0, 16'h0999, 0, "full_resume");
        chk("full_resume:addr", {30'd0, im_addr}, 32'd0);

        // Asynchronous reset between edges with a write pending.
        do_start("ar_start");
        cycle(1, 0, 0, 1, 2, 3, 0, 0, 0, "ar0");
        in_valid = 0;
        #1 rstn = 1'b0;
        #1;
        chk("ar:we", {31'd0, im_we}, 32'd0);
        chk("ar:addr", {30'd0, im_addr}, 32'd0);
        chk("ar:wdata", im_wdata, 32'd0);
        chk("ar:count", {29'd0, count}, 32'd0);
        chk("ar:ready", {31'd0, in_ready}, 32'd1);
        #1 rstn = 1'b1;
        model_clear();
        @(posedge clk); #1;
        check_outputs("ar_after");
        cycle(1, 0, 5, 3, 4, 5, 0, 0, 0, "ar_next");
        chk("ar_next:addr", {30'd0, im_addr}, 32'd0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535),
                  $urandom_range(0, 32'h3FFFFFF), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
